// File: rtl/pe_lin_array.sv
// Linear chain of N multiply-accumulate PEs. Activations enter PE 0 and shift one PE per cycle.
// A frame ends when the last-tagged activation reaches PE N-1; the result is then held until it is consumed.
module pe_lin_array #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int AW = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   w_load,
  input  logic [N-1:0][DW-1:0]   in_w,
  input  logic                   fire,
  input  logic [DW-1:0]          in_a,
  input  logic                   last,
  output logic                   in_ready,
  output logic [N-1:0][AW-1:0]   outs,
  output logic                   ovf,
  output logic                   out_valid,
  input  logic                   out_ready
);

  // state | meaning
  // IDLE  | waiting for the first activation of a frame; weights may be loaded
  // RUN   | frame in progress, accepting activations
  // DRAIN | last activation accepted, waiting for it to reach PE N-1
  // DONE  | frame result presented on outs/ovf until out_ready
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int CW = (N > 2) ? $clog2(N - 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((N >= 2) ? (N - 2) : 0);
  // wide enough for acc + w*a without wrapping
  localparam int SW = ((AW > 2 * DW) ? AW : 2 * DW) + 1;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [N-1:0][DW-1:0]  w_reg;
  logic [N-1:0][DW-1:0]  a_reg;
  logic [N-1:0]          f_reg;
  logic [N-1:0]          l_reg;
  logic [N-1:0][AW-1:0]  acc;

  logic                  accepted;
  logic                  clear;
  logic [N-1:0]          f_in;
  logic [N-1:0][DW-1:0]  a_in;
  logic [N-1:0]          l_in;
  logic [N-1:0][SW-1:0]  sum;
  logic [N-1:0]          sat_hit;
  logic [N-1:0][AW-1:0]  acc_nxt;

  assign in_ready  = ((state == IDLE) && !w_load) || (state == RUN);
  assign accepted  = fire && in_ready;
  assign clear     = (state == DONE) && out_ready;
  assign out_valid = (state == DONE);
  assign outs      = acc;

  always_comb begin
    f_in    = '0;
    a_in    = '0;
    l_in    = '0;
    sum     = '0;
    sat_hit = '0;
    acc_nxt = '0;
    f_in[0] = accepted;
    a_in[0] = in_a;
    l_in[0] = last;
    for (int i = 1; i < N; i++) begin
      f_in[i] = f_reg[i-1];
      a_in[i] = a_reg[i-1];
      l_in[i] = l_reg[i-1];
    end
    for (int i = 0; i < N; i++) begin
      sum[i]     = SW'(acc[i]) + SW'(w_reg[i]) * SW'(a_in[i]);
      sat_hit[i] = f_in[i] && (sum[i][SW-1:AW] != '0);
      acc_nxt[i] = sat_hit[i] ? {AW{1'b1}} : sum[i][AW-1:0];
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE, RUN: begin
        if (accepted && last) begin
          state_nxt = (N == 1) ? DONE : DRAIN;
          cnt_nxt   = CNT_INIT;
        end else if (accepted) begin
          state_nxt = RUN;
        end
      end
      DRAIN: begin
        if (cnt == '0) state_nxt = DONE;
        else cnt_nxt = cnt - 1'b1;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      w_reg <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (w_load && (state == IDLE)) w_reg <= in_w;
    end
  end

  // a_reg is deliberately not cleared at frame end; it is only observed alongside f_reg
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= '0;
      f_reg <= '0;
      l_reg <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
    end else if (clear) begin
      f_reg <= '0;
      l_reg <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        f_reg[i] <= f_in[i];
        if (f_in[i]) begin
          a_reg[i] <= a_in[i];
          l_reg[i] <= l_in[i];
          acc[i]   <= acc_nxt[i];
        end
      end
      if (|sat_hit) ovf <= 1'b1;
    end
  end

endmodule

// File: doc/pe_lin_array.md
PE_LIN_ARRAY -- requirements
Module: pe_lin_array

Interface
REQ-001 SHALL have parameter N, default 4: number of PEs in the linear chain, N >= 1.
REQ-002 SHALL have parameter DW, default 8: unsigned weight and activation width.
REQ-003 SHALL have parameter AW, default 12: unsigned accumulator and output width, AW >= 1.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port w_load  input  1  weight-load strobe.
REQ-007 SHALL have port in_w  input  N x DW  per-PE weights; element i feeds PE i.
REQ-008 SHALL have port fire  input  1  activation-valid request.
REQ-009 SHALL have port in_a  input  DW  activation entering PE 0.
REQ-010 SHALL have port last  input  1  marks the accepted activation as the final one of the frame.
REQ-011 SHALL have port in_ready  output  1  activation accept indicator.
REQ-012 SHALL have port outs  output  N x AW  per-PE accumulator values.
REQ-013 SHALL have port ovf  output  1  sticky saturation flag for the current frame.
REQ-014 SHALL have port out_valid  output  1  frame result available.
REQ-015 SHALL have port out_ready  input  1  consumer accepts the frame result.

Function
REQ-016 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-017 SHALL drive in_ready combinationally as (IDLE and not w_load) or RUN.
REQ-018 SHALL define an activation as accepted when fire and in_ready are both high.
REQ-019 SHALL load w_reg from in_w on w_load only in IDLE.
REQ-020 SHALL ignore w_load in every state other than IDLE.
REQ-021 SHALL ignore fire, in_a and last whenever in_ready is low; the values SHALL NOT enter the pipeline.
REQ-022 SHALL hold per PE i: a_reg[i], f_reg[i], l_reg[i] and acc[i].
REQ-023 SHALL take PE 0 inputs as (accepted, in_a, last) and PE i>0 inputs as (f_reg[i-1], a_reg[i-1], l_reg[i-1]).
REQ-024 When its fire input is high, PE i SHALL register the input activation and last tag.
REQ-025 When its fire input is high, PE i SHALL set f_reg[i] to 1 and update acc[i] to sat(acc[i] + w_reg[i]*a_in).
REQ-026 When its fire input is low, PE i SHALL set f_reg[i] to 0 and hold acc[i], a_reg[i] and l_reg[i].
REQ-027 SHALL compute the multiply-accumulate at full width and saturate the result to 2^AW-1.
REQ-028 SHALL set ovf on any saturation in any PE and hold it until the frame is cleared.
REQ-029 SHALL give PE i a fixed latency of i cycles relative to PE 0; bubbles (fire low) between accepted activations SHALL propagate unchanged.
REQ-030 SHALL drive outs[i] = acc[i] continuously.
REQ-031 SHALL transition IDLE -> RUN on an accepted activation with last low.
REQ-032 On an accepted activation with last high (from IDLE or RUN), SHALL go to DONE if N=1, else to DRAIN with cnt = N-2.
REQ-033 In DRAIN, SHALL go to DONE when cnt = 0, else decrement cnt.
REQ-034 SHALL enter DONE on exactly the edge at which PE N-1 absorbs the last-tagged activation, i.e. N-1 edges after the last accept.
REQ-035 SHALL assert out_valid exactly in DONE and hold outs and ovf stable while out_valid is high.
REQ-036 On DONE with out_ready high at an edge, SHALL clear all acc, ovf, f_reg and l_reg and go to IDLE; out_valid SHALL drop after that edge.
REQ-037 SHALL ignore out_ready outside DONE.
REQ-038 SHALL retain w_reg across frames until the next honoured w_load.

Reset
REQ-039 On rst high, SHALL immediately and asynchronously clear all acc, a_reg, f_reg, l_reg, w_reg, cnt and ovf, and set state to IDLE.
REQ-040 After reset, SHALL drive outs all 0, out_valid 0, ovf 0 and in_ready 1 (with w_load low).
REQ-041 Reset asserted in any state, including mid-DRAIN, SHALL abandon the frame with no out_valid pulse.
REQ-042 After rst deasserts, SHALL process the next accepted activation normally.

Verification (N=4, DW=8, AW=12)
REQ-043 The bench SHALL cover: rst pulse with no clock -> outs 0, out_valid 0, ovf 0, in_ready 1 immediately.
REQ-044 The bench SHALL cover: w_load {1,2,3,4}; then a=1,2,3 on consecutive cycles with last on a=3 -> in_ready 0 from the edge after the last accept; out_valid rises 3 edges after the last accept; outs = {6,12,18,24}; ovf 0.
REQ-045 The bench SHALL cover: w=1 for all PEs; fire a=5; two bubble cycles; fire a=5 with last; plus w_load and fire together in IDLE -> the fire in that cycle is ignored; outs = {10,10,10,10}.
REQ-046 The bench SHALL cover: w=255 for all PEs; single a=255 with last -> outs = {4095 x4}; ovf 1; cleared to 0 after the out_ready handshake.
REQ-047 The bench SHALL cover: hold out_ready low for 5 cycles in DONE while fire toggles -> outs stable and fire ignored; then out_ready high for 1 cycle -> next cycle outs 0, out_valid 0, in_ready 1.
REQ-048 The bench SHALL cover: rst asserted during DRAIN -> immediate clear; no out_valid pulse; a subsequent frame yields correct sums.
